// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic-cycle slave with NUM_REGS byte-lane-writable registers and WAIT_STATES wait cycles.
// Define WB_SLAVE_REGFILE_ERR_EN to terminate out-of-range accesses with err_o instead of ack_o.
module wb_slave_regfile #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned GRANULE     = 8,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         adr_i,
  input  logic [DATA_WIDTH-1:0]         dat_i,
  output logic [DATA_WIDTH-1:0]         dat_o,
  input  logic [DATA_WIDTH/GRANULE-1:0] sel_i,
  input  logic                          we_i,
  input  logic                          cyc_i,
  input  logic                          stb_i,
  output logic                          ack_o,
  output logic                          err_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int unsigned LSB       = $clog2(SEL_WIDTH);
  localparam int unsigned IDX_W     = $clog2(NUM_REGS);
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_commit;
  logic                  w_req;
  logic                  w_oor;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_ack;

  assign w_req = cyc_i & stb_i;
  assign w_idx = adr_i[LSB +: IDX_W];
  // Any address bit above the index field set means the access misses the bank.
  assign w_oor = |(adr_i >> (LSB + IDX_W));

  // Expand byte-lane selects into a bit mask.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      w_mask[k*GRANULE +: GRANULE] = {GRANULE{sel_i[k]}};
    end
  end

  // Next-state: w_commit marks the edge that enters ACK, where the transfer takes effect.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = S_ACK;
            w_commit    = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == '0) begin
          w_state_nxt = S_ACK;
          w_commit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Register bank and read data; both only change on the committing edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_dat <= '0;
    end else if (w_commit) begin
      if (we_i) begin
        if (!w_oor) begin
          r_regs[w_idx] <= (r_regs[w_idx] & ~w_mask) | (dat_i & w_mask);
        end
      end else begin
`ifdef WB_SLAVE_REGFILE_ERR_EN
        if (!w_oor) begin
          r_dat <= r_regs[w_idx] & w_mask;
        end
`else
        r_dat <= w_oor ? '0 : (r_regs[w_idx] & w_mask);
`endif
      end
    end
  end

`ifdef WB_SLAVE_REGFILE_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_commit & ~w_oor;
      r_err <= w_commit & w_oor;
    end
  end

  assign err_o = r_err;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_commit;
    end
  end

  assign err_o = 1'b0;
`endif

  assign ack_o = r_ack;
  assign dat_o = r_dat;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Scoreboard bench for wb_slave_regfile (NUM_REGS=8, WAIT_STATES=2) with a lane-level register model.
// Honours WB_SLAVE_REGFILE_ERR_EN when the design is built with it.
module tb_wb_slave_regfile;

  localparam int WS = 2;
`ifdef WB_SLAVE_REGFILE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;
  logic        err_o;

  typedef struct {
    bit          err;
    logic [31:0] dat;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[8];
  logic [31:0] last_rd;
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_xfer = 0;

  wb_slave_regfile #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .GRANULE    (8),
    .NUM_REGS   (8),
    .WAIT_STATES(WS)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .adr_i(adr_i),
    .dat_i(dat_i),
    .dat_o(dat_o),
    .sel_i(sel_i),
    .we_i (we_i),
    .cyc_i(cyc_i),
    .stb_i(stb_i),
    .ack_o(ack_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1, "watchdog");
  end

  // Monitor: every termination pops the oldest expected response.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && (ack_o || err_o)) begin
      n_vec++;
      if (ack_o && err_o) begin
        n_bad++;
        $display("FAIL ack_err_both: ack_o=%b err_o=%b, required never both high", ack_o, err_o);
      end else if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_term: ack_o=%b err_o=%b with no transfer outstanding", ack_o, err_o);
      end else begin
        e = sb.pop_front();
        if (err_o !== e.err || dat_o !== e.dat) begin
          n_bad++;
          $display("FAIL xfer%0d: err_o=%b dat_o=%08h, required err_o=%b dat_o=%08h",
                   e.id, err_o, dat_o, e.err, e.dat);
        end
      end
    end
  end

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[k*8 +: 8] = s[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    last_rd = 32'h0;
  endtask

  task automatic xfer(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input bit w);
    exp_t e;
    int   idx;
    bit   oor;
    int   cyc_n;
    idx = (int'(a) / 4) % 8;
    oor = (int'(a) >= 32);
    e.err = oor && ERR_EN;
    if (oor) begin
      if (!w && !ERR_EN) last_rd = 32'h0;
    end else if (w) begin
      for (int k = 0; k < 4; k++) if (s[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
    end else begin
      last_rd = model[idx] & lane_mask(s);
    end
    e.dat = last_rd;
    e.id  = n_xfer++;
    sb.push_back(e);
    @(negedge clk_i);
    adr_i = a; dat_i = d; sel_i = s; we_i = w; cyc_i = 1'b1; stb_i = 1'b1;
    cyc_n = 0;
    do begin
      @(posedge clk_i);
      #1;
      cyc_n++;
    end while (!(ack_o || err_o) && cyc_n < 20);
    n_vec++;
    if (cyc_n != WS + 1) begin
      n_bad++;
      $display("FAIL latency xfer%0d: terminated after %0d edges, required %0d", e.id, cyc_n, WS + 1);
    end
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic abort_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, input int hold);
    bit seen;
    seen = 1'b0;
    @(negedge clk_i);
    adr_i = a; dat_i = d; sel_i = s; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_i); #1;
      seen |= (ack_o || err_o);
    end
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      seen |= (ack_o || err_o);
    end
    n_vec++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort adr=%04h: termination seen=1, required 0", a);
    end
  endtask

  task automatic reset_mid_write();
    bit seen;
    seen = 1'b0;
    @(negedge clk_i);
    adr_i = 16'h0000; dat_i = 32'hA5A5_5A5A; sel_i = 4'hF; we_i = 1'b1; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge clk_i); #1;
      seen |= (ack_o || err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      seen |= (ack_o || err_o);
    end
    n_vec++;
    if (seen || dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid: termination seen=%b dat_o=%08h, required 0 and 00000000", seen, dat_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    adr_i = '0; dat_i = '0; sel_i = '0; we_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_vec++;
    if (ack_o !== 1'b0 || err_o !== 1'b0 || dat_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: ack_o=%b err_o=%b dat_o=%08h, required 0 0 00000000", ack_o, err_o, dat_o);
    end

    xfer(16'h0004, 32'h0, 4'hF, 1'b0);
    xfer(16'h0008, 32'hDEADBEEF, 4'hF, 1'b1);
    xfer(16'h0008, 32'h0, 4'hF, 1'b0);
    xfer(16'h0008, 32'h11223344, 4'h5, 1'b1);
    xfer(16'h0008, 32'h0, 4'hF, 1'b0);
    xfer(16'h0008, 32'h0, 4'h3, 1'b0);

    xfer(16'h0020, 32'hCAFEF00D, 4'hF, 1'b1);
    xfer(16'h0020, 32'h0, 4'hF, 1'b0);
    for (int i = 0; i < 8; i++) xfer(16'(i * 4), 32'h0, 4'hF, 1'b0);

    xfer(16'h000C, 32'h55AA1234, 4'hF, 1'b1);
    abort_wr(16'h000C, 32'h99999999, 4'hF, 1);
    xfer(16'h000C, 32'h0, 4'hF, 1'b0);

    reset_mid_write();
    xfer(16'h0000, 32'h0, 4'hF, 1'b0);
    xfer(16'h0000, 32'h0BAD_F00D, 4'hF, 1'b1);
    xfer(16'h0000, 32'h0, 4'hF, 1'b0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        abort_wr(16'($urandom_range(0, 31)), $urandom, 4'($urandom), int'($urandom_range(1, 2)));
      end else begin
        xfer(16'($urandom_range(0, 47)), $urandom, 4'($urandom), 1'($urandom));
      end
    end

    repeat (4) @(posedge clk_i);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_slave_regfile.md
# wb_slave_regfile

Wishbone B4 classic-cycle slave holding a parametrised bank of byte-lane-writable registers. It generalises the single-register slave in three ways: N registers, a programmable number of wait states, and an optional error response for out-of-range addresses. It sits behind the interconnect as a generic control/status register block for peripherals.

## Interface
- ADDR_WIDTH, 16, width of adr_i (byte address)
- DATA_WIDTH, 32, data bus width; multiple of GRANULE
- GRANULE, 8, bits per select lane; SEL_WIDTH = DATA_WIDTH/GRANULE
- NUM_REGS, 8, register count; power of two, 2..256
- WAIT_STATES, 0, extra cycles inserted before ack; 0..15
- clk_i  input  1  single clock, all logic on rising edge
- rst_i  input  1  reset; asynchronous, active-high
- adr_i  input  ADDR_WIDTH  byte address
- dat_i  input  DATA_WIDTH  write data from master
- dat_o  output  DATA_WIDTH  read data to master
- sel_i  input  SEL_WIDTH  byte-lane select
- we_i  input  1  1 = write, 0 = read
- cyc_i  input  1  bus cycle valid
- stb_i  input  1  strobe
- ack_o  output  1  normal termination, one-cycle pulse
- err_o  output  1  error termination, one-cycle pulse (tied 0 unless the macro is defined)

## Operation
- Word index = adr_i[LSB +: log2(NUM_REGS)], with LSB = log2(SEL_WIDTH). Low LSB address bits are ignored. The address is out of range when any bit above the index field is non-zero.
- FSM states: IDLE, WAIT, ACK.
  - IDLE -> WAIT when cyc_i & stb_i are sampled high and WAIT_STATES > 0; the wait counter loads WAIT_STATES-1.
  - IDLE -> ACK directly when WAIT_STATES = 0.
  - WAIT decrements the counter each cycle and goes to ACK at 0.
  - WAIT -> IDLE (abort) if cyc_i or stb_i is low: no write, no ack, counter cleared.
  - ACK -> IDLE unconditionally after one cycle.
- Commit happens on the edge entering ACK, using adr_i/dat_i/sel_i/we_i sampled at that edge. The master holds these stable until ack.
  - Write: for each lane k with sel_i[k]=1, reg[idx][k*GRANULE +: GRANULE] <= dat_i lane k. Unselected lanes are unchanged. sel_i = 0 still acks and changes nothing.
  - Read: dat_o <= reg[idx] with unselected lanes forced to 0. dat_o holds until the next read commit; writes do not change dat_o.
- A write and a read of the same register never overlap (one transfer in flight).
- Out-of-range access without the macro: acked normally; write discarded; read returns 0.
- All registers, dat_o, ack_o, err_o, the FSM (IDLE) and the counter reset to 0. Reset mid-transfer aborts the transfer with no ack and no write.

## Timing
- Latency from the edge sampling cyc_i&stb_i high to ack_o high: WAIT_STATES+1 cycles. ack_o stays high exactly one cycle.
- Minimum back-to-back period: WAIT_STATES+2 cycles. The IDLE cycle after ACK does not sample a new request until the next edge.
- cyc_i & stb_i asserted in the same cycle that ack_o is high is not a new request; the FSM is in ACK then.
- ack_o and err_o are never high together.

## Configuration
- WB_SLAVE_REGFILE_ERR_EN defined: an out-of-range access terminates with err_o (same timing as ack_o) and ack_o stays low. No write occurs and dat_o is unchanged.
- Undefined: err_o is constant 0 and out-of-range handling is as described in Operation.

## Test plan
Defaults throughout, except NUM_REGS=8 and WAIT_STATES=2.
- Reset, then read addr 0x0004 sel 0xF -> ack 3 cycles after strobe; dat_o = 0x00000000.
- Write 0xDEADBEEF to 0x0008 sel 0xF, then read 0x0008 sel 0xF -> 0xDEADBEEF.
- Write 0x11223344 to 0x0008 sel 0x5, then read sel 0xF -> 0xDE22BE44. Read sel 0x3 -> 0x0000BE44.
- Write to 0x0020, then read it -> without macro: ack, data 0, registers 0..7 unchanged. With WB_SLAVE_REGFILE_ERR_EN: err_o pulse, ack_o low.
- Drop stb_i/cyc_i one cycle after a write request to 0x000C -> no ack; a following read of 0x000C returns the previous value.
- Assert rst_i during WAIT of a write to 0x0000 -> no ack; after release, read 0x0000 returns 0 and the FSM accepts the request normally.
